// File: rtl/undo_history_stack_pkg.sv
// Shared types and sizing for the calculator undo history.
// The stack itself treats a snapshot as opaque bits; only the FSM packs and unpacks the fields.
package undo_history_stack_pkg;

  typedef struct packed {
    logic [1:0]  estado;
    logic [1:0]  operacion;
    logic [16:0] sumando1;
    logic [16:0] sumando2;
  } snapshot_t;

  localparam int unsigned SNAP_W     = $bits(snapshot_t);
  localparam int unsigned UNDO_DEPTH = 8;

endpackage

// File: rtl/undo_history_stack_lifo_ram.sv
// Snapshot storage for the undo stack: one write port, asynchronous read.
// Kept separate so the array can be mapped to BRAM or LUTRAM without touching the control logic.
module undo_history_stack_lifo_ram #(
  parameter int unsigned DATA_W = 38,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned AddrW  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AddrW-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AddrW-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/undo_history_stack.sv
// Bounded LIFO of calculator snapshots; when full, a push silently overwrites the oldest entry.
// Pops return data one cycle later on data_out, which holds until the next successful pop.
module undo_history_stack
  import undo_history_stack_pkg::*;
#(
  parameter int unsigned DATA_W = SNAP_W,
  parameter int unsigned DEPTH  = UNDO_DEPTH,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              pop_valid,
  output logic              pop_err,
  output logic              overflow,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              pop_valid_q, pop_valid_d;
  logic              pop_err_q, pop_err_d;
  logic              overflow_q, overflow_d;

  logic              ram_we;
  logic [PtrW-1:0]   ram_waddr;
  logic [PtrW-1:0]   top_ptr;
  logic [DATA_W-1:0] top_data;

  assign top_ptr = wr_ptr_q - PtrW'(1);
  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));

  always_comb begin
    ram_we      = 1'b0;
    ram_waddr   = wr_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    pop_valid_d = 1'b0;
    pop_err_d   = 1'b0;
    overflow_d  = 1'b0;
    case ({push, pop})
      2'b10: begin
        ram_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (full) begin
          overflow_d = 1'b1;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      2'b01: begin
        if (empty) begin
          pop_err_d = 1'b1;
        end else begin
          data_out_d  = top_data;
          wr_ptr_d    = top_ptr;
          count_d     = count_q - CNT_W'(1);
          pop_valid_d = 1'b1;
        end
      end
      2'b11: begin
        if (empty) begin
          // Nothing to pop: the push still lands as the first entry.
          ram_we    = 1'b1;
          wr_ptr_d  = wr_ptr_q + PtrW'(1);
          count_d   = CNT_W'(1);
          pop_err_d = 1'b1;
        end else begin
          // Read of the old top is asynchronous, so replacing it in place is safe.
          ram_we      = 1'b1;
          ram_waddr   = top_ptr;
          data_out_d  = top_data;
          pop_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      pop_valid_q <= 1'b0;
      pop_err_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      pop_valid_q <= pop_valid_d;
      pop_err_q   <= pop_err_d;
      overflow_q  <= overflow_d;
    end
  end

  undo_history_stack_lifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AddrW  (PtrW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we & ~reset),
    .waddr_i (ram_waddr),
    .wdata_i (data_in),
    .raddr_i (top_ptr),
    .rdata_o (top_data)
  );

  assign data_out  = data_out_q;
  assign pop_valid = pop_valid_q;
  assign pop_err   = pop_err_q;
  assign overflow  = overflow_q;
  assign count     = count_q;

endmodule

// File: tb/tb_undo_history_stack.sv
// Directed vector bench for undo_history_stack with DEPTH=8, DATA_W=38.
module tb_undo_history_stack;

  localparam int unsigned DW = 38;
  localparam int unsigned CW = 4;

  typedef struct {
    logic          push;
    logic          pop;
    logic [DW-1:0] din;
    logic [DW-1:0] e_dout;
    logic          e_pv;
    logic          e_pe;
    logic          e_ov;
    logic [CW-1:0] e_cnt;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          pop_valid, pop_err, overflow, empty, full;
  logic [CW-1:0] count;

  int total = 0;
  int bad = 0;
  vec_t vecs[$];

  undo_history_stack u_dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .data_in   (data_in),
    .data_out  (data_out),
    .pop_valid (pop_valid),
    .pop_err   (pop_err),
    .overflow  (overflow),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic pu, input logic po, input logic [DW-1:0] d,
                              input logic [DW-1:0] ed, input logic pv, input logic pe,
                              input logic ov, input int cnt);
    vec_t v;
    v.push = pu; v.pop = po; v.din = d; v.e_dout = ed;
    v.e_pv = pv; v.e_pe = pe; v.e_ov = ov; v.e_cnt = CW'(cnt);
    vecs.push_back(v);
  endfunction

  task automatic step(input logic rst, input logic pu, input logic po, input logic [DW-1:0] d);
    @(negedge clk);
    reset = rst; push = pu; pop = po; data_in = d;
    @(posedge clk);
    #1;
    reset = 1'b0; push = 1'b0; pop = 1'b0;
  endtask

  task automatic check(input string name, input logic [DW-1:0] ed, input logic pv,
                       input logic pe, input logic ov, input logic [CW-1:0] cnt);
    logic [DW+6:0] act, exp;
    act = {data_out, pop_valid, pop_err, overflow, count, empty, full};
    exp = {ed, pv, pe, ov, cnt, (cnt == 0), (cnt == 8)};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got dout=%h pv=%b pe=%b ov=%b cnt=%0d e=%b f=%b want dout=%h pv=%b pe=%b ov=%b cnt=%0d e=%b f=%b",
               name, data_out, pop_valid, pop_err, overflow, count, empty, full,
               ed, pv, pe, ov, cnt, (cnt == 0), (cnt == 8));
    end
  endtask

  initial begin
    logic [DW-1:0] last;
    logic [DW-1:0] d;
    logic [31:0]   r0, r1;

    // Pop on empty, then LIFO order on three entries.
    add(0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 0, 1);
    add(1, 0, 2, 0, 0, 0, 0, 2);
    add(1, 0, 3, 0, 0, 0, 0, 3);
    add(0, 1, 0, 3, 1, 0, 0, 2);
    add(0, 1, 0, 2, 1, 0, 0, 1);
    add(0, 1, 0, 1, 1, 0, 0, 0);
    add(0, 1, 0, 1, 0, 1, 0, 0);
    // Ten pushes into eight slots: oldest two are lost.
    for (int i = 1; i <= 10; i++) add(1, 0, DW'(i), 1, 0, 0, (i > 8), (i > 8) ? 8 : i);
    add(0, 0, 0, 1, 0, 0, 0, 8);
    for (int i = 10; i >= 3; i--) add(0, 1, 0, DW'(i), 1, 0, 0, i - 3);
    add(0, 1, 0, 3, 0, 1, 0, 0);
    // Replace-top on simultaneous push+pop.
    add(1, 0, 'hAA, 3, 0, 0, 0, 1);
    add(1, 0, 'hBB, 3, 0, 0, 0, 2);
    add(1, 1, 'hCC, 'hBB, 1, 0, 0, 2);
    add(0, 1, 0, 'hCC, 1, 0, 0, 1);
    add(0, 1, 0, 'hAA, 1, 0, 0, 0);
    // Push+pop on empty behaves as a push plus an error.
    add(1, 1, 'hDD, 'hAA, 0, 1, 0, 1);
    add(0, 1, 0, 'hDD, 1, 0, 0, 0);

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("reset", 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      step(0, vecs[i].push, vecs[i].pop, vecs[i].din);
      check($sformatf("vec%0d", i), vecs[i].e_dout, vecs[i].e_pv, vecs[i].e_pe,
            vecs[i].e_ov, vecs[i].e_cnt);
    end
    last = 'hDD;

    // Reset together with a push drops all history and ignores the push.
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, DW'(i + 'h50));
      check($sformatf("fill%0d", i), last, 0, 0, 0, CW'(i + 1));
    end
    step(1, 1, 0, 'h77);
    check("reset_push", 0, 0, 0, 0, 0);
    step(0, 0, 1, 0);
    check("pop_after_reset", 0, 0, 1, 0, 0);

    // Alternating push/pop with random data.
    last = '0;
    for (int i = 0; i < 20; i++) begin
      r0 = $urandom;
      r1 = $urandom;
      d = {r1[5:0], r0};
      step(0, 1, 0, d);
      check($sformatf("alt_push%0d", i), last, 0, 0, 0, 1);
      step(0, 0, 1, 0);
      check($sformatf("alt_pop%0d", i), d, 1, 0, 0, 0);
      last = d;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
